// File: rtl/sr_cmd_pkg.sv
// Package for the SR command generator: FSM state and command encodings, button
// lane indices and the minimum legal debounce length.
// Ports: none (package).
package sr_cmd_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_REL} state_t;
   typedef enum logic [1:0] {CMD_NONE, CMD_SET, CMD_RST} cmd_t;

   localparam int DEBOUNCE_CYCLES_MIN = 2;

   // Button lanes, packed as {rst, set}
   localparam int NUM_BTN = 2;
   localparam int BTN_SET = 0;
   localparam int BTN_RST = 1;

endpackage

// File: rtl/sr_debounce.sv
// One button lane: 2-flop synchroniser, debounce counter, clean level and rise pulse.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   raw       asynchronous, bouncing button input
//   stable    debounced level
//   rise      one-cycle pulse on the cycle after stable goes 0->1
module sr_debounce
   import sr_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_param
      $error("sr_debounce: DEBOUNCE_CYCLES below minimum");
   end

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          stable_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync     <= '0;
         cnt      <= '0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
      end else begin
         sync     <= {sync[0], raw};
         stable_d <= stable;
         // Any agreeing cycle restarts the run, so bounces shorter than
         // DEBOUNCE_CYCLES never move the clean level.
         if (sync[1] == stable) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync[1];
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign rise = stable & ~stable_d;

endmodule

// File: rtl/sr_cmd_gen.sv
// SR command generator: debounces the set/reset buttons and turns each press into a
// single en strobe carrying s or r, re-arming only once both buttons are released.
// Counts issued strobes.
// Build option: define SR_RESET_PRIORITY_EN to turn a simultaneous press into a reset
// command; otherwise a simultaneous press issues nothing.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   btn_set, btn_rst   raw asynchronous buttons
//   s, r               command bits, meaningful only while en=1
//   en                 one-cycle command strobe
//   busy               FSM not in IDLE
//   cmd_count          strobes issued, wraps silently
module sr_cmd_gen
   import sr_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_set,
   input  logic             btn_rst,
   output logic             s,
   output logic             r,
   output logic             en,
   output logic             busy,
   output logic [CNT_W-1:0] cmd_count
);

   logic [NUM_BTN-1:0] raw, stable, rise;

   assign raw[BTN_SET] = btn_set;
   assign raw[BTN_RST] = btn_rst;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .rst    (rst),
         .raw    (raw[i]),
         .stable (stable[i]),
         .rise   (rise[i])
      );
   end

   // Reset forgets the buttons, so a button held through reset would look like a
   // fresh press once its debouncer catches up. Presses are only accepted after the
   // debouncers have had time to settle and have then seen both buttons released.
   // A held button reaches stable=1 DEBOUNCE_CYCLES+2 edges after reset; one extra
   // cycle of margin is added.
   localparam int SETTLE = DEBOUNCE_CYCLES + 3;
   localparam int SW     = $clog2(SETTLE + 1);

   logic [SW-1:0] settle_cnt;
   logic          settled, armed;

   assign settled = (settle_cnt == SW'(SETTLE));

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= '0;
         armed      <= 1'b0;
      end else begin
         if (!settled) settle_cnt <= settle_cnt + SW'(1);
         if (settled && stable == '0) armed <= 1'b1;
      end
   end

   state_t state, state_nxt;
   cmd_t   cmd, cmd_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cmd       <= CMD_NONE;
         cmd_count <= '0;
      end else begin
         state <= state_nxt;
         cmd   <= cmd_nxt;
         if (state == ISSUE) cmd_count <= cmd_count + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_nxt   = cmd;
      case (state)
         IDLE: begin
            if (armed && rise[BTN_SET] && rise[BTN_RST]) begin
`ifdef SR_RESET_PRIORITY_EN
               state_nxt = ISSUE;
               cmd_nxt   = CMD_RST;
`else
               // Conflict: issue nothing, just wait for both to be released
               state_nxt = WAIT_REL;
               cmd_nxt   = CMD_NONE;
`endif
            end else if (armed && rise[BTN_SET]) begin
               state_nxt = ISSUE;
               cmd_nxt   = CMD_SET;
            end else if (armed && rise[BTN_RST]) begin
               state_nxt = ISSUE;
               cmd_nxt   = CMD_RST;
            end
         end
         ISSUE:    state_nxt = WAIT_REL;
         WAIT_REL: begin
            if (stable == '0) begin
               state_nxt = IDLE;
               cmd_nxt   = CMD_NONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cmd_nxt   = CMD_NONE;
         end
      endcase
   end

   // Outputs decode the state register only, so they are glitch-free and s/r are
   // forced low outside ISSUE.
   always_comb begin
      en   = (state == ISSUE);
      s    = en && (cmd == CMD_SET);
      r    = en && (cmd == CMD_RST);
      busy = (state != IDLE);
   end

endmodule

// File: tb/tb_sr_cmd_gen.sv
module tb_sr_cmd_gen;
   localparam int D     = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst, btn_set, btn_rst;
   logic             s, r, en, busy;
   logic [CNT_W-1:0] cmd_count;

   always #5 clk = ~clk;

   sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_set   (btn_set),
      .btn_rst   (btn_rst),
      .s         (s),
      .r         (r),
      .en        (en),
      .busy      (busy),
      .cmd_count (cmd_count)
   );

   typedef struct {
      logic             s;
      logic             r;
      int               cyc;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t             sb[$];
   int               cyc    = 0;
   int               n_chk  = 0;
   int               n_err  = 0;
   int               n_en   = 0;
   int               exp_en = 0;
   logic [CNT_W-1:0] mcnt   = '0;
   logic             en_q   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive(input logic bs, input logic br);
      @(negedge clk);
      btn_set = bs;
      btn_rst = br;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called right after a clean press is driven: the strobe is due in the cycle
   // after edge (now+1)+D+2, carrying the count value before this strobe.
   task automatic expect_cmd(input logic es, input logic er);
      exp_t e;
      e.s   = es;
      e.r   = er;
      e.cyc = cyc + D + 3;
      e.cnt = mcnt;
      mcnt  = mcnt + 1'b1;
      exp_en++;
      sb.push_back(e);
   endtask

   // Output monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (en === 1'b1) begin
         n_en++;
         chk("en_twice", {31'd0, en_q & en}, 0);
         if (sb.size() == 0) begin
            chk("unexp_en", {29'd0, s, r, en}, 0);
         end else begin
            e = sb.pop_front();
            chk("s", {31'd0, s}, {31'd0, e.s});
            chk("r", {31'd0, r}, {31'd0, e.r});
            chk("cnt_at_en", {24'd0, cmd_count}, {24'd0, e.cnt});
            chk("latency", cyc, e.cyc);
         end
      end else if (cyc > 0) begin
         chk("sr_idle", {30'd0, s, r}, 0);
      end
      en_q = en;
   end

   initial begin
      rst     = 1'b1;
      btn_set = 1'b0;
      btn_rst = 1'b0;

      // 1: reset held with buttons toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_out", {28'd0, s, r, en, busy}, 0);
         chk("rst_cnt", {24'd0, cmd_count}, 0);
         btn_set = ~btn_set;
         btn_rst = i[0];
      end
      rst     = 1'b0;
      btn_set = 1'b0;
      btn_rst = 1'b0;
      idle(15);

      // 2: clean set press, latency, count, busy release timing
      drive(1, 0);
      expect_cmd(1, 0);
      idle(12);
      chk("busy_wait", {31'd0, busy}, 1);
      chk("cnt_1", {24'd0, cmd_count}, 1);
      drive(0, 0);
      idle(D + 2);
      chk("busy_hold", {31'd0, busy}, 1);
      idle(1);
      chk("busy_rel", {31'd0, busy}, 0);
      idle(5);

      // 3: bouncing reset button, then held
      for (int i = 0; i < 3; i++) begin
         drive(0, 1);
         idle(1);
         drive(0, 0);
         idle(1);
      end
      drive(0, 1);
      expect_cmd(0, 1);
      idle(15);
      chk("cnt_bounce", {24'd0, cmd_count}, {24'd0, mcnt});
      drive(0, 0);
      idle(12);
      chk("busy_bounce", {31'd0, busy}, 0);

      // 4: simultaneous press
      drive(1, 1);
`ifdef SR_RESET_PRIORITY_EN
      expect_cmd(0, 1);
`endif
      idle(D + 4);
      chk("busy_both", {31'd0, busy}, 1);
      chk("cnt_both", {24'd0, cmd_count}, {24'd0, mcnt});
      drive(0, 1);
      idle(15);
      chk("busy_one_held", {31'd0, busy}, 1);
      drive(0, 0);
      idle(D + 4);
      chk("busy_both_rel", {31'd0, busy}, 0);
      idle(5);

      // 5: second button pressed while first is held -> no second strobe
      drive(1, 0);
      expect_cmd(1, 0);
      idle(12);
      drive(1, 1);
      idle(15);
      chk("busy_ovl", {31'd0, busy}, 1);
      chk("cnt_ovl", {24'd0, cmd_count}, {24'd0, mcnt});
      drive(0, 0);
      idle(12);
      chk("busy_ovl_rel", {31'd0, busy}, 0);

      // 6: reset in the ISSUE cycle with the button still held
      drive(1, 0);
      expect_cmd(1, 0);
      idle(D + 3);
      rst  = 1'b1;
      mcnt = '0;
      @(negedge clk);
      chk("rst_iss_en", {31'd0, en}, 0);
      chk("rst_iss_cnt", {24'd0, cmd_count}, 0);
      chk("rst_iss_busy", {31'd0, busy}, 0);
      rst = 1'b0;
      idle(30);
      chk("held_no_issue", {24'd0, cmd_count}, 0);
      chk("held_idle", {31'd0, busy}, 0);
      drive(0, 0);
      idle(15);
      drive(1, 0);
      expect_cmd(1, 0);
      idle(12);
      chk("repress_cnt", {24'd0, cmd_count}, 1);
      drive(0, 0);
      idle(12);

      // Wrap: 256 clean presses from a fresh reset
      rst  = 1'b1;
      mcnt = '0;
      idle(2);
      rst = 1'b0;
      idle(12);
      for (int i = 0; i < 256; i++) begin
         if (i[0]) begin
            drive(0, 1);
            expect_cmd(0, 1);
         end else begin
            drive(1, 0);
            expect_cmd(1, 0);
         end
         idle(D + 5);
         drive(0, 0);
         idle(D + 5);
      end
      chk("wrap", {24'd0, cmd_count}, 0);

      idle(5);
      chk("sb_empty", sb.size(), 0);
      chk("n_en", n_en, exp_en);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
